// File: rtl/quick_spi_txn_scheduler.sv
// quick_spi_txn_scheduler
// Command-queue front end for the quick_spi_hard master. Host commands
// {slave, op, data} are buffered in a small FIFO, launched one at a time on
// the core's start/operation interface, and read results are queued in a
// response FIFO for the host to collect.
// Optional feature macro: SPI_SCHED_TIMEOUT_EN adds a WAIT_EOT watchdog that
// aborts a stuck transaction and reports it through timeout / rsp_err.
module quick_spi_txn_scheduler #(
  parameter int   OUT_W          = 16,
  parameter int   IN_W           = 8,
  parameter int   SLAVES         = 2,
  parameter int   CMD_DEPTH      = 4,
  parameter int   RSP_DEPTH      = 4,
  parameter logic READ_OP        = 1'b1,
  parameter int   GAP_CYCLES     = 2,
  parameter int   TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sched_en,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [SLAVES-1:0] cmd_slave,
  input  logic              cmd_op,
  input  logic [OUT_W-1:0]  cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IN_W-1:0]   rsp_data,
  output logic [SLAVES-1:0] rsp_slave,
  output logic              rsp_err,
  output logic              busy,
  output logic              timeout,
  output logic              spi_enable,
  output logic              spi_start_transaction,
  output logic [SLAVES-1:0] spi_slave,
  output logic              spi_operation,
  output logic [OUT_W-1:0]  spi_outgoing_data,
  input  logic              spi_end_of_transaction,
  input  logic [IN_W-1:0]   spi_incoming_data
);

  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int CCW = $clog2(CMD_DEPTH + 1);
  localparam int RAW = $clog2(RSP_DEPTH);
  localparam int RCW = $clog2(RSP_DEPTH + 1);
  localparam int GCW = $clog2(GAP_CYCLES + 1);
  localparam logic [CCW-1:0] CMD_FULL = CCW'(CMD_DEPTH);
  localparam logic [RCW-1:0] RSP_FULL = RCW'(RSP_DEPTH);
  localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_CYCLES - 1);

  // Reject parameter sets the pointer arithmetic cannot support
  if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_cmd_depth
    $error("CMD_DEPTH must be a power of two >= 2");
  end
  if (RSP_DEPTH < 2 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0) begin : g_bad_rsp_depth
    $error("RSP_DEPTH must be a power of two >= 2");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("GAP_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_EOT,
    GAP
  } state_t;

  state_t state;
  logic [GCW-1:0] gap_cnt;

  // Command FIFO storage and bookkeeping
  logic [SLAVES-1:0] cmd_slave_mem [CMD_DEPTH];
  logic              cmd_op_mem    [CMD_DEPTH];
  logic [OUT_W-1:0]  cmd_data_mem  [CMD_DEPTH];
  logic [CAW-1:0]    cmd_wr_ptr;
  logic [CAW-1:0]    cmd_rd_ptr;
  logic [CCW-1:0]    cmd_count;
  logic              cmd_pending;
  logic              cmd_push;
  logic              cmd_pop;

  // Response FIFO storage and bookkeeping
  logic [IN_W-1:0]   rsp_data_mem  [RSP_DEPTH];
  logic [SLAVES-1:0] rsp_slave_mem [RSP_DEPTH];
  logic [RAW-1:0]    rsp_wr_ptr;
  logic [RAW-1:0]    rsp_rd_ptr;
  logic [RCW-1:0]    rsp_count;
  logic              rsp_full;
  logic              rsp_push;
  logic              rsp_pop;
  logic [IN_W-1:0]   rsp_push_data;

  logic head_is_read;
  logic launch_go;

`ifdef SPI_SCHED_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT_CYCLES - 1);
  logic           rsp_err_mem [RSP_DEPTH];
  logic           rsp_push_err;
  logic [TCW-1:0] wdog_cnt;
  logic           wdog_hit;
  logic           timeout_q;
`endif

  assign cmd_ready = (cmd_count != CMD_FULL);
  assign cmd_push  = cmd_valid && cmd_ready;
  assign rsp_valid = (rsp_count != '0);
  assign rsp_full  = (rsp_count == RSP_FULL);
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign busy      = (state != IDLE) || (cmd_count != '0);

  assign rsp_data  = rsp_valid ? rsp_data_mem[rsp_rd_ptr] : '0;
  assign rsp_slave = rsp_valid ? rsp_slave_mem[rsp_rd_ptr] : '0;

`ifdef SPI_SCHED_TIMEOUT_EN
  assign rsp_err  = rsp_valid ? rsp_err_mem[rsp_rd_ptr] : 1'b0;
  assign timeout  = timeout_q;
  assign wdog_hit = (state == WAIT_EOT) && !spi_end_of_transaction && (wdog_cnt == TO_LAST);
`else
  assign rsp_err  = 1'b0;
  assign timeout  = 1'b0;
`endif

  // A read is only launched when its response is guaranteed a free slot
  assign head_is_read = (cmd_op_mem[cmd_rd_ptr] == READ_OP);
  assign launch_go    = (state == IDLE) && sched_en && cmd_pending && (!head_is_read || !rsp_full);
  assign cmd_pop      = launch_go;

  // Decide what (if anything) the finishing transaction writes into the response FIFO
  always_comb begin
    rsp_push      = 1'b0;
    rsp_push_data = spi_incoming_data;
`ifdef SPI_SCHED_TIMEOUT_EN
    rsp_push_err  = 1'b0;
`endif
    if ((state == WAIT_EOT) && spi_end_of_transaction && (spi_operation == READ_OP)) begin
      rsp_push = 1'b1;
    end
`ifdef SPI_SCHED_TIMEOUT_EN
    if (wdog_hit && (spi_operation == READ_OP)) begin
      rsp_push      = 1'b1;
      rsp_push_data = '0;
      rsp_push_err  = 1'b1;
    end
`endif
  end

  // Command FIFO payload storage; contents need no reset because the count gates them
  always_ff @(posedge clk) begin
    if (cmd_push) begin
      cmd_slave_mem[cmd_wr_ptr] <= cmd_slave;
      cmd_op_mem[cmd_wr_ptr]    <= cmd_op;
      cmd_data_mem[cmd_wr_ptr]  <= cmd_data;
    end
  end

  // Command FIFO pointers and count; cmd_pending lags the count so a new entry is seen one clk later
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_wr_ptr  <= '0;
      cmd_rd_ptr  <= '0;
      cmd_count   <= '0;
      cmd_pending <= 1'b0;
    end else begin
      if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + 1'b1;
      if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + 1'b1;
      case ({cmd_push, cmd_pop})
        2'b10:   cmd_count <= cmd_count + 1'b1;
        2'b01:   cmd_count <= cmd_count - 1'b1;
        default: cmd_count <= cmd_count;
      endcase
      cmd_pending <= (cmd_count != '0) && !cmd_pop;
    end
  end

  // Response FIFO payload storage
  always_ff @(posedge clk) begin
    if (rsp_push) begin
      rsp_data_mem[rsp_wr_ptr]  <= rsp_push_data;
      rsp_slave_mem[rsp_wr_ptr] <= spi_slave;
`ifdef SPI_SCHED_TIMEOUT_EN
      rsp_err_mem[rsp_wr_ptr]   <= rsp_push_err;
`endif
    end
  end

  // Response FIFO pointers and count; simultaneous push and pop are both honoured
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_wr_ptr <= '0;
      rsp_rd_ptr <= '0;
      rsp_count  <= '0;
    end else begin
      if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + 1'b1;
      if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + 1'b1;
      case ({rsp_push, rsp_pop})
        2'b10:   rsp_count <= rsp_count + 1'b1;
        2'b01:   rsp_count <= rsp_count - 1'b1;
        default: rsp_count <= rsp_count;
      endcase
    end
  end

  // Transaction sequencer: pop, raise start, wait for end-of-transaction, then idle gap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                 <= IDLE;
      gap_cnt               <= '0;
      spi_enable            <= 1'b0;
      spi_start_transaction <= 1'b0;
      spi_slave             <= '0;
      spi_operation         <= 1'b0;
      spi_outgoing_data     <= '0;
`ifdef SPI_SCHED_TIMEOUT_EN
      wdog_cnt              <= '0;
      timeout_q             <= 1'b0;
`endif
    end else begin
      spi_enable <= sched_en || (state != IDLE);
`ifdef SPI_SCHED_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (launch_go) begin
            spi_slave         <= cmd_slave_mem[cmd_rd_ptr];
            spi_operation     <= cmd_op_mem[cmd_rd_ptr];
            spi_outgoing_data <= cmd_data_mem[cmd_rd_ptr];
            state             <= LAUNCH;
          end
        end
        LAUNCH: begin
          spi_start_transaction <= 1'b1;
`ifdef SPI_SCHED_TIMEOUT_EN
          wdog_cnt              <= '0;
`endif
          state                 <= WAIT_EOT;
        end
        WAIT_EOT: begin
          if (spi_end_of_transaction) begin
            spi_start_transaction <= 1'b0;
            gap_cnt               <= '0;
            state                 <= GAP;
          end
`ifdef SPI_SCHED_TIMEOUT_EN
          else if (wdog_hit) begin
            spi_start_transaction <= 1'b0;
            timeout_q             <= 1'b1;
            gap_cnt               <= '0;
            state                 <= GAP;
          end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
          end
`endif
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quick_spi_txn_scheduler.sv
// tb_quick_spi_txn_scheduler
// Scoreboard bench: expected launches and responses are queued as commands are
// driven, and popped when the scheduler launches on the core or returns data.
// A behavioural core answers each start with an end-of-transaction pulse and
// returns the low byte of the outgoing payload as read data.
// Define SPI_SCHED_TIMEOUT_EN to also exercise the watchdog scenario.
module tb_quick_spi_txn_scheduler;

  localparam int   OUT_W      = 16;
  localparam int   IN_W       = 8;
  localparam int   SLAVES     = 2;
  localparam logic READ_OP    = 1'b1;
  localparam int   TB_TIMEOUT = 16;
  localparam int   CORE_LAT   = 3;

  typedef struct packed {
    logic [SLAVES-1:0] slave;
    logic              op;
    logic [OUT_W-1:0]  data;
  } txn_t;

  typedef struct packed {
    logic [IN_W-1:0]   data;
    logic [SLAVES-1:0] slave;
    logic              err;
  } rsp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sched_en = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [SLAVES-1:0] cmd_slave = '0;
  logic              cmd_op = 1'b0;
  logic [OUT_W-1:0]  cmd_data = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [IN_W-1:0]   rsp_data;
  logic [SLAVES-1:0] rsp_slave;
  logic              rsp_err;
  logic              busy;
  logic              timeout;
  logic              spi_enable;
  logic              spi_start_transaction;
  logic [SLAVES-1:0] spi_slave;
  logic              spi_operation;
  logic [OUT_W-1:0]  spi_outgoing_data;
  logic              spi_end_of_transaction;
  logic [IN_W-1:0]   spi_incoming_data;

  logic core_auto = 1'b1;
  int   core_cnt;
  logic core_done;
  logic start_d;

  txn_t exp_launch[$];
  txn_t obs_launch[$];
  rsp_t exp_rsp[$];

  int n_checks = 0;
  int n_fail   = 0;

  quick_spi_txn_scheduler #(
    .OUT_W(OUT_W), .IN_W(IN_W), .SLAVES(SLAVES), .CMD_DEPTH(4), .RSP_DEPTH(4),
    .READ_OP(READ_OP), .GAP_CYCLES(2), .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sched_en(sched_en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_slave(cmd_slave),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_slave(rsp_slave), .rsp_err(rsp_err), .busy(busy), .timeout(timeout),
    .spi_enable(spi_enable), .spi_start_transaction(spi_start_transaction),
    .spi_slave(spi_slave), .spi_operation(spi_operation),
    .spi_outgoing_data(spi_outgoing_data),
    .spi_end_of_transaction(spi_end_of_transaction),
    .spi_incoming_data(spi_incoming_data)
  );

  always #5 clk = ~clk;

  // Behavioural SPI core: CORE_LAT clks after seeing start, pulse end-of-transaction once
  always @(posedge clk) begin
    if (!rst_n) begin
      spi_end_of_transaction <= 1'b0;
      spi_incoming_data      <= '0;
      core_cnt               <= 0;
      core_done              <= 1'b0;
    end else begin
      spi_end_of_transaction <= 1'b0;
      if (!spi_start_transaction) begin
        core_done <= 1'b0;
        core_cnt  <= 0;
      end else if (core_auto && !core_done) begin
        if (core_cnt == CORE_LAT) begin
          spi_end_of_transaction <= 1'b1;
          spi_incoming_data      <= spi_outgoing_data[IN_W-1:0];
          core_done              <= 1'b1;
        end else begin
          core_cnt <= core_cnt + 1;
        end
      end
    end
  end

  // Launch monitor: record the core-side fields each time start rises
  always @(posedge clk) begin
    if (!rst_n) begin
      start_d <= 1'b0;
    end else begin
      start_d <= spi_start_transaction;
      if (spi_start_transaction && !start_d) begin
        obs_launch.push_back({spi_slave, spi_operation, spi_outgoing_data});
      end
    end
  end

  // Absolute backstop so the run always ends
  initial begin
    #400000;
    $display("[TB] FAIL global_watchdog: got no completion, expected completion before time limit");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic send_cmd(input logic [SLAVES-1:0] s, input logic o, input logic [OUT_W-1:0] d);
    txn_t t;
    rsp_t r;
    for (int i = 0; i < 300 && !cmd_ready; i++) @(negedge clk);
    if (!cmd_ready) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL cmd_accept_wait: got cmd_ready=0, expected 1 within bound");
    end else begin
      cmd_valid = 1'b1; cmd_slave = s; cmd_op = o; cmd_data = d;
      t.slave = s; t.op = o; t.data = d;
      exp_launch.push_back(t);
      if (o == READ_OP) begin
        r.data = d[IN_W-1:0]; r.slave = s; r.err = 1'b0;
        exp_rsp.push_back(r);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_launch(output txn_t t);
    t = '0;
    for (int i = 0; i < 400 && obs_launch.size() == 0; i++) @(negedge clk);
    if (obs_launch.size() == 0) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL launch_wait: got no launch, expected a launch within bound");
    end else begin
      t = obs_launch.pop_front();
    end
  endtask

  task automatic pop_rsp(output rsp_t r);
    r = '0;
    for (int i = 0; i < 400 && !rsp_valid; i++) @(negedge clk);
    if (!rsp_valid) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL rsp_wait: got rsp_valid=0, expected 1 within bound");
    end else begin
      r = {rsp_data, rsp_slave, rsp_err};
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_cmd_ready: got %b, expected 1", cmd_ready); end
    n_checks++;
    if ({rsp_valid, rsp_data, rsp_slave, rsp_err} !== '0) begin
      n_fail++; $display("[TB] FAIL reset_rsp: got %b/%h/%b/%b, expected all 0", rsp_valid, rsp_data, rsp_slave, rsp_err);
    end
    n_checks++;
    if ({busy, timeout, spi_enable, spi_start_transaction} !== 4'b0) begin
      n_fail++; $display("[TB] FAIL reset_status: got busy/to/en/start=%b%b%b%b, expected 0000", busy, timeout, spi_enable, spi_start_transaction);
    end
    n_checks++;
    if ({spi_slave, spi_operation, spi_outgoing_data} !== '0) begin
      n_fail++; $display("[TB] FAIL reset_spi_fields: got %b/%b/%h, expected 0", spi_slave, spi_operation, spi_outgoing_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    txn_t t, e;
    bit   moved;
    int   k;
    $display("[TB] test_write");
    sched_en = 1'b1;
    core_auto = 1'b1;
    send_cmd(2'b01, 1'b0, 16'hCC82);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (spi_start_transaction !== (i == 3)) begin
        n_fail++; $display("[TB] FAIL launch_latency_%0d: got start=%b, expected %b", i, spi_start_transaction, (i == 3));
      end
    end
    wait_launch(t);
    e = exp_launch.pop_front();
    n_checks++;
    if (t !== e) begin n_fail++; $display("[TB] FAIL write_launch: got %h, expected %h", t, e); end
    moved = 1'b0;
    k = 0;
    while (spi_end_of_transaction !== 1'b1 && k < 100) begin
      if ({spi_slave, spi_operation, spi_outgoing_data} !== e) moved = 1'b1;
      @(negedge clk);
      k++;
    end
    if ({spi_slave, spi_operation, spi_outgoing_data} !== e) moved = 1'b1;
    n_checks++;
    if (moved || k >= 100) begin n_fail++; $display("[TB] FAIL write_hold: got moved=%b waited=%0d, expected stable fields until EOT", moved, k); end
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (spi_start_transaction !== 1'b0) begin
        n_fail++; $display("[TB] FAIL write_gap_%0d: got start=%b, expected 0", i, spi_start_transaction);
      end
    end
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL write_no_rsp: got rsp_valid=%b, expected 0", rsp_valid); end
  endtask

  task automatic test_read();
    txn_t t, e;
    rsp_t r, er;
    int   k;
    $display("[TB] test_read");
    send_cmd(2'b01, READ_OP, 16'h00A9);
    wait_launch(t);
    e = exp_launch.pop_front();
    n_checks++;
    if (t !== e) begin n_fail++; $display("[TB] FAIL read_launch: got %h, expected %h", t, e); end
    k = 0;
    while (spi_end_of_transaction !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL read_rsp_early: got rsp_valid=%b, expected 0", rsp_valid); end
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL read_rsp_latency: got rsp_valid=%b, expected 1", rsp_valid); end
    pop_rsp(r);
    er = exp_rsp.pop_front();
    n_checks++;
    if (r !== er) begin n_fail++; $display("[TB] FAIL read_rsp: got %h, expected %h", r, er); end
  endtask

  task automatic test_cmd_full();
    txn_t t, e;
    rsp_t r, er;
    txn_t ent;
    rsp_t rent;
    $display("[TB] test_cmd_full");
    sched_en = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_slave = i[1:0];
      cmd_op    = i[0];
      cmd_data  = 16'hA0B0 + 16'(i);
      n_checks++;
      if (cmd_ready !== (i < 4)) begin
        n_fail++; $display("[TB] FAIL full_ready_%0d: got cmd_ready=%b, expected %b", i, cmd_ready, (i < 4));
      end
      if (i < 4) begin
        ent.slave = i[1:0]; ent.op = i[0]; ent.data = 16'hA0B0 + 16'(i);
        exp_launch.push_back(ent);
        if (i[0] == READ_OP) begin
          rent.data = 8'hB0 + 8'(i); rent.slave = i[1:0]; rent.err = 1'b0;
          exp_rsp.push_back(rent);
        end
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    n_checks++;
    if ({cmd_ready, busy, spi_start_transaction} !== 3'b010) begin
      n_fail++; $display("[TB] FAIL full_idle: got ready/busy/start=%b%b%b, expected 010", cmd_ready, busy, spi_start_transaction);
    end
    sched_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_launch(t);
      e = exp_launch.pop_front();
      n_checks++;
      if (t !== e) begin n_fail++; $display("[TB] FAIL full_order_%0d: got %h, expected %h", i, t, e); end
    end
    repeat (30) @(negedge clk);
    n_checks++;
    if (obs_launch.size() != 0) begin n_fail++; $display("[TB] FAIL full_extra_launch: got %0d extra, expected 0", obs_launch.size()); end
    for (int i = 0; i < 2; i++) begin
      pop_rsp(r);
      er = exp_rsp.pop_front();
      n_checks++;
      if (r !== er) begin n_fail++; $display("[TB] FAIL full_rsp_%0d: got %h, expected %h", i, r, er); end
    end
  endtask

  task automatic test_rsp_full();
    txn_t t, e;
    rsp_t r, er;
    bit   started;
    $display("[TB] test_rsp_full");
    rsp_ready = 1'b0;
    sched_en  = 1'b1;
    for (int i = 0; i < 5; i++) send_cmd(2'b10, READ_OP, 16'h3C40 + 16'(i));
    for (int i = 0; i < 4; i++) begin
      wait_launch(t);
      e = exp_launch.pop_front();
      n_checks++;
      if (t !== e) begin n_fail++; $display("[TB] FAIL rspfull_launch_%0d: got %h, expected %h", i, t, e); end
    end
    started = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (spi_start_transaction === 1'b1 && spi_outgoing_data === 16'h3C44) started = 1'b1;
    end
    n_checks++;
    if (started || obs_launch.size() != 0) begin
      n_fail++; $display("[TB] FAIL rspfull_hold: got launched=%b pending=%0d, expected 5th held", started, obs_launch.size());
    end
    n_checks++;
    if ({rsp_valid, busy, spi_start_transaction} !== 3'b110) begin
      n_fail++; $display("[TB] FAIL rspfull_status: got valid/busy/start=%b%b%b, expected 110", rsp_valid, busy, spi_start_transaction);
    end
    pop_rsp(r);
    er = exp_rsp.pop_front();
    n_checks++;
    if (r !== er) begin n_fail++; $display("[TB] FAIL rspfull_rsp_0: got %h, expected %h", r, er); end
    wait_launch(t);
    e = exp_launch.pop_front();
    n_checks++;
    if (t !== e) begin n_fail++; $display("[TB] FAIL rspfull_launch_4: got %h, expected %h", t, e); end
    for (int i = 1; i < 5; i++) begin
      pop_rsp(r);
      er = exp_rsp.pop_front();
      n_checks++;
      if (r !== er) begin n_fail++; $display("[TB] FAIL rspfull_rsp_%0d: got %h, expected %h", i, r, er); end
    end
  endtask

  task automatic test_reset_mid();
    txn_t t, e;
    $display("[TB] test_reset_mid");
    core_auto = 1'b1;
    sched_en  = 1'b1;
    send_cmd(2'b01, READ_OP, 16'h0077);
    wait_launch(t);
    e = exp_launch.pop_front();
    n_checks++;
    if (t !== e) begin n_fail++; $display("[TB] FAIL rstmid_read_launch: got %h, expected %h", t, e); end
    for (int i = 0; i < 100 && !rsp_valid; i++) @(negedge clk);
    core_auto = 1'b0;
    send_cmd(2'b10, 1'b0, 16'h5555);
    wait_launch(t);
    e = exp_launch.pop_front();
    n_checks++;
    if (t !== e) begin n_fail++; $display("[TB] FAIL rstmid_write_launch: got %h, expected %h", t, e); end
    send_cmd(2'b11, 1'b0, 16'h6666);
    n_checks++;
    if ({spi_start_transaction, rsp_valid, busy} !== 3'b111) begin
      n_fail++; $display("[TB] FAIL rstmid_pre: got start/valid/busy=%b%b%b, expected 111", spi_start_transaction, rsp_valid, busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({spi_start_transaction, spi_enable, rsp_valid, busy} !== 4'b0) begin
      n_fail++; $display("[TB] FAIL rstmid_post: got start/en/valid/busy=%b%b%b%b, expected 0000", spi_start_transaction, spi_enable, rsp_valid, busy);
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_cmd_ready: got %b, expected 1", cmd_ready); end
    rst_n = 1'b1;
    exp_launch.delete();
    exp_rsp.delete();
    obs_launch.delete();
    core_auto = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++;
    if (obs_launch.size() != 0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rstmid_flushed: got launches=%0d rsp_valid=%b, expected 0/0", obs_launch.size(), rsp_valid);
    end
  endtask

`ifdef SPI_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    txn_t t, e;
    rsp_t r, er;
    int   k;
    $display("[TB] test_timeout");
    core_auto = 1'b0;
    sched_en  = 1'b1;
    send_cmd(2'b01, READ_OP, 16'h00EE);
    void'(exp_rsp.pop_back());
    er.data = '0; er.slave = 2'b01; er.err = 1'b1;
    exp_rsp.push_back(er);
    for (int i = 0; i < 20 && spi_start_transaction !== 1'b1; i++) @(negedge clk);
    k = 0;
    while (timeout !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    n_checks++;
    if (k != TB_TIMEOUT) begin n_fail++; $display("[TB] FAIL timeout_latency: got %0d clks, expected %0d", k, TB_TIMEOUT); end
    n_checks++;
    if (spi_start_transaction !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_start: got %b, expected 0", spi_start_transaction); end
    @(negedge clk);
    n_checks++;
    if (timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_pulse: got %b, expected 0", timeout); end
    wait_launch(t);
    e = exp_launch.pop_front();
    n_checks++;
    if (t !== e) begin n_fail++; $display("[TB] FAIL timeout_launch: got %h, expected %h", t, e); end
    pop_rsp(r);
    er = exp_rsp.pop_front();
    n_checks++;
    if (r !== er) begin n_fail++; $display("[TB] FAIL timeout_rsp: got %h, expected %h", r, er); end
    core_auto = 1'b1;
    send_cmd(2'b10, 1'b0, 16'h1234);
    wait_launch(t);
    e = exp_launch.pop_front();
    n_checks++;
    if (t !== e) begin n_fail++; $display("[TB] FAIL timeout_next: got %h, expected %h", t, e); end
  endtask
`endif

  // Scenario sequence
  initial begin
    test_reset();
    test_write();
    test_read();
    test_cmd_full();
    test_rsp_full();
    test_reset_mid();
`ifdef SPI_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
